// File: rtl/shift_sequencer.sv
// Multi-cycle left-shift controller: shifts an operand one bit per clock and
// returns result, last carry-out and sticky overflow over a valid/ready pair.
module shift_sequencer #(
  parameter int WIDTH = 12,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready
  // (and no abort); a result transfers on an edge where out_valid && out_ready.
  // Valid-side payload is held stable until the transfer completes.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [AMT_W-1:0] count_q;
  logic             carry_q;
  logic             ovf_q;

  // 1-bit left shifter: WIDTH in, WIDTH+1 out (MSB is the shifted-out bit)
  logic [WIDTH:0]   shl_d;
  assign shl_d = {acc_q, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q   <= operand;
            count_q <= amount;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= (amount == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= shl_d[WIDTH-1:0];
          carry_q <= shl_d[WIDTH];
          ovf_q   <= ovf_q | shl_d[WIDTH];
          count_q <= count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == SHIFT) || (state_q == DONE);
  assign result      = acc_q;
  assign carry_out   = carry_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: arithmetic reference model checked every
// cycle, plus hand-computed per-transaction expectations.
module tb_shift_sequencer;
  localparam int W = 12;
  localparam int A = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  operand = '0;
  logic [A-1:0]  amount = '0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;
  logic          busy;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .amount(amount), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out),
    .overflow(overflow), .busy(busy), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 shifting, 2 result pending.
  int           m_phase = 0;
  int           m_left = 0;
  bit           m_zero = 1'b1;
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0;
  logic         m_o = 1'b0;
  logic [31:0]  full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_zero = 1'b1; m_res = '0; m_c = 1'b0; m_o = 1'b0;
    end else if (abort) begin
      m_phase = 0; m_zero = 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          full    = 32'(operand) << amount;
          m_res   = full[W-1:0];
          m_o     = |full[31:W];
          m_c     = full[W];
          m_left  = int'(amount);
          m_zero  = 1'b0;
          m_phase = (amount == '0) ? 2 : 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("m_in_ready", 32'(in_ready), 32'(m_phase == 0));
      check("m_out_valid", 32'(out_valid), 32'(m_phase == 2));
      check("m_busy", 32'(busy), 32'(m_phase != 0));
      if (m_phase == 2) begin
        check("m_result", 32'(result), 32'(m_res));
        check("m_carry", 32'(carry_out), 32'(m_c));
        check("m_ovf", 32'(overflow), 32'(m_o));
      end else if (m_phase == 0 && m_zero) begin
        check("m_zero_res", 32'(result), 32'd0);
        check("m_zero_carry", 32'(carry_out), 32'd0);
        check("m_zero_ovf", 32'(overflow), 32'd0);
      end
    end
  end

  task automatic do_txn(input logic [W-1:0] op, input logic [A-1:0] amt, input int hold,
                        input bit poke, input logic [W-1:0] e_res, input logic e_c,
                        input logic e_o, input int e_lat);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; operand = op; amount = amt; out_ready = 1'b0;
    @(posedge clk); #1;
    if (poke) begin
      operand = 12'hFFF; amount = '0;
    end else begin
      in_valid = 1'b0;
    end
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(e_lat));
    check("result", 32'(result), 32'(e_res));
    check("carry_out", 32'(carry_out), 32'(e_c));
    check("overflow", 32'(overflow), 32'(e_o));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(e_res));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("ready_after_hs", 32'(in_ready), 32'd1);
    check("valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #17;
    check("reset_result", 32'(result), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(in_ready), 32'd1);
    chk_en = 1'b1;

    do_txn(12'd12,  4'd1,  0, 1'b0, 12'd24,  1'b0, 1'b0, 2);
    do_txn(12'h801, 4'd1,  0, 1'b0, 12'h002, 1'b1, 1'b1, 2);
    do_txn(12'h0F0, 4'd0,  0, 1'b0, 12'h0F0, 1'b0, 1'b0, 1);
    do_txn(12'hFFF, 4'd15, 5, 1'b0, 12'h000, 1'b0, 1'b1, 16);
    do_txn(12'h0A5, 4'd12, 0, 1'b0, 12'h000, 1'b1, 1'b1, 13);
    do_txn(12'h400, 4'd2,  2, 1'b1, 12'h000, 1'b1, 1'b1, 3);
    do_txn(12'h002, 4'd13, 0, 1'b0, 12'h000, 1'b0, 1'b1, 14);

    // abort mid-shift
    @(posedge clk); #1;
    in_valid = 1'b1; operand = 12'd3; amount = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_result", 32'(result), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_txn(12'd3, 4'd2, 0, 1'b0, 12'd12, 1'b0, 1'b0, 3);

    // abort beats in_valid in IDLE
    @(posedge clk); #1;
    in_valid = 1'b1; abort = 1'b1; operand = 12'h123; amount = 4'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_vs_in_busy", 32'(busy), 32'd0);

    // abort beats out_ready in DONE and clears the result
    @(posedge clk); #1;
    in_valid = 1'b1; operand = 12'h0F0; amount = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_abort_valid", 32'(out_valid), 32'd1);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("done_abort_result", 32'(result), 32'd0);

    // asynchronous reset mid-shift
    @(posedge clk); #1;
    in_valid = 1'b1; operand = 12'h005; amount = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", 32'(in_ready), 32'd1);
    do_txn(12'd12, 4'd1, 0, 1'b0, 12'd24, 1'b0, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
